// File: rtl/etroc_sync_pkg.sv
// Shared definitions for the ETROC2 frame-sync lock/error supervisor:
// per-channel state codes and the resync counter width.
package etroc_sync_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_UNLOCKED = 3'd0;
  localparam state_t ST_LOCKED   = 3'd1;
  localparam state_t ST_RESYNC   = 3'd2;
  localparam state_t ST_HOLDOFF  = 3'd3;
  localparam state_t ST_FAILED   = 3'd4;

  localparam int RESYNC_CNT_W = 8;

  // Saturating increment for the resync counter (sticks at 255).
  function automatic logic [RESYNC_CNT_W-1:0] rs_sat_inc(input logic [RESYNC_CNT_W-1:0] v);
    return (v == '1) ? v : v + RESYNC_CNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_sync_ch_fsm.sv
// One channel of the frame-sync supervisor: lock qualification, sticky
// error flag with saturating error counter, bounded forced-resync retries
// with holdoff, and a terminal FAILED state left only by clr_error/reset.
module frame_sync_ch_fsm
  import etroc_sync_pkg::*;
#(
  parameter int LOCK_CYCLES    = 16,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int MAX_RESYNC     = 8,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_error,
  input  logic                    enable_auto_sync,
  input  logic                    aligned,
  input  logic                    trig_synched,
  input  logic                    link_consistent,
  input  logic                    data_valid,
  input  logic                    transient_error,
  output logic                    force_resync,
  output logic                    data_error,
  output logic                    ch_failed,
  output logic [2:0]              ch_state,
  output logic [CNT_W-1:0]        err_count,
  output logic [RESYNC_CNT_W-1:0] resync_count
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [LOCK_W-1:0] LOCK_TARGET = LOCK_W'(LOCK_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX     = '1;

  state_t                  state_q, state_d;
  logic [LOCK_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic                    err_flag_q, err_flag_d;
  logic [RESYNC_CNT_W-1:0] rs_cnt_q, rs_cnt_d;
  logic [RESYNC_CNT_W-1:0] rs_inc;
  logic                    qual;

  assign qual = aligned & trig_synched;

  // The resync count a RESYNC cycle would commit; a same-cycle clear
  // restarts it from zero so a clear-triggered resync leaves it at 1.
  assign rs_inc = rs_sat_inc(clr_error ? '0 : rs_cnt_q);

  // State and counter registers; reset returns the channel to UNLOCKED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_UNLOCKED;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      rs_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      rs_cnt_q   <= rs_cnt_d;
    end
  end

  // Next-state logic; clr_error outranks every other condition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (lock_cnt_q == LOCK_TARGET) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (clr_error)                                state_d = ST_RESYNC;
        else if (!qual)                               state_d = ST_UNLOCKED;
        else if (enable_auto_sync && !link_consistent) state_d = ST_RESYNC;
      end
      ST_RESYNC: begin
        if (MAX_RESYNC != 0 && int'(rs_inc) >= MAX_RESYNC) state_d = ST_FAILED;
        else                                               state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_UNLOCKED;
      end
      ST_FAILED: begin
        if (clr_error) state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // Counter datapath: lock/holdoff timers, error count and resync count.
  always_comb begin
    lock_cnt_d = '0;
    hold_cnt_d = '0;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    rs_cnt_d   = clr_error ? '0 : rs_cnt_q;

    // Lock timer runs only while unlocked; any gap in qualification restarts it.
    if (state_q == ST_UNLOCKED && lock_cnt_q != LOCK_TARGET && qual)
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);

    // Holdoff timer starts at zero on entry and stops at the exit cycle.
    if (state_q == ST_HOLDOFF && state_d == ST_HOLDOFF)
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);

    // Errors only count while locked; a coincident clear wins.
    if (clr_error) begin
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (state_q == ST_LOCKED && data_valid && transient_error) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    if (state_q == ST_RESYNC) rs_cnt_d = rs_inc;
  end

  // Outputs decode registered state only, so reset removes them at once.
  always_comb begin
    force_resync = (state_q == ST_RESYNC);
    ch_failed    = (state_q == ST_FAILED);
    ch_state     = state_q;
    data_error   = err_flag_q;
    err_count    = err_cnt_q;
    resync_count = rs_cnt_q;
  end

endmodule

// File: rtl/etroc_multi_frame_sync_monitor.sv
// Multi-channel ETROC2 frame-sync supervisor: one independent channel FSM
// per link, packed status buses and an all-channels-locked summary.
module etroc_multi_frame_sync_monitor
  import etroc_sync_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int LOCK_CYCLES    = 16,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int MAX_RESYNC     = 8,
  parameter int CNT_W          = 16
) (
  input  logic                   clk40,
  input  logic                   reset,
  input  logic                   clr_error,
  input  logic [NCH-1:0]         enable_auto_sync,
  input  logic [NCH-1:0]         aligned,
  input  logic [NCH-1:0]         trig_synched,
  input  logic [NCH-1:0]         link_consistent,
  input  logic [NCH-1:0]         data_valid,
  input  logic [NCH-1:0]         transient_error,
  output logic [NCH-1:0]         force_resync,
  output logic [NCH-1:0]         data_error,
  output logic [NCH-1:0]         ch_failed,
  output logic [3*NCH-1:0]       ch_state,
  output logic [CNT_W*NCH-1:0]   err_count,
  output logic [8*NCH-1:0]       resync_count,
  output logic                   all_locked
);

  logic [NCH-1:0] locked_vec;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      frame_sync_ch_fsm #(
        .LOCK_CYCLES   (LOCK_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
        .MAX_RESYNC    (MAX_RESYNC),
        .CNT_W         (CNT_W)
      ) u_ch (
        .clk             (clk40),
        .rst             (reset),
        .clr_error       (clr_error),
        .enable_auto_sync(enable_auto_sync[gi]),
        .aligned         (aligned[gi]),
        .trig_synched    (trig_synched[gi]),
        .link_consistent (link_consistent[gi]),
        .data_valid      (data_valid[gi]),
        .transient_error (transient_error[gi]),
        .force_resync    (force_resync[gi]),
        .data_error      (data_error[gi]),
        .ch_failed       (ch_failed[gi]),
        .ch_state        (ch_state[3*gi +: 3]),
        .err_count       (err_count[CNT_W*gi +: CNT_W]),
        .resync_count    (resync_count[RESYNC_CNT_W*gi +: RESYNC_CNT_W])
      );

      assign locked_vec[gi] = (ch_state[3*gi +: 3] == ST_LOCKED);
    end
  endgenerate

  // Channel states are registered, so this reduction tracks them with no extra delay.
  always_comb begin
    all_locked = &locked_vec;
  end

endmodule

// File: tb/tb_etroc_multi_frame_sync_monitor.sv
// Bench for the frame-sync supervisor: a default-parameter 4-channel DUT
// and a small DUT (LOCK=4, HOLDOFF=8, MAX_RESYNC=3, CNT_W=4) for the
// saturation and retry-limit cases. Vectors hold per-channel stimulus and
// the expected status of one channel after `rep` clocks.
module tb_etroc_multi_frame_sync_monitor;

  logic clk40 = 1'b0;
  always #12 clk40 = ~clk40;

  logic reset;

  // main DUT
  logic        m_clr;
  logic [3:0]  m_en, m_al, m_ts, m_lc, m_dv, m_te;
  logic [3:0]  m_fr, m_de, m_fail;
  logic [11:0] m_state;
  logic [63:0] m_err;
  logic [31:0] m_rs;
  logic        m_all;

  // small DUT
  logic        s_clr;
  logic [1:0]  s_en, s_al, s_ts, s_lc, s_dv, s_te;
  logic [1:0]  s_fr, s_de, s_fail;
  logic [5:0]  s_state;
  logic [7:0]  s_err;
  logic [15:0] s_rs;
  logic        s_all;

  etroc_multi_frame_sync_monitor #(
    .NCH(4), .LOCK_CYCLES(16), .HOLDOFF_CYCLES(64), .MAX_RESYNC(8), .CNT_W(16)
  ) dut (
    .clk40(clk40), .reset(reset), .clr_error(m_clr),
    .enable_auto_sync(m_en), .aligned(m_al), .trig_synched(m_ts),
    .link_consistent(m_lc), .data_valid(m_dv), .transient_error(m_te),
    .force_resync(m_fr), .data_error(m_de), .ch_failed(m_fail),
    .ch_state(m_state), .err_count(m_err), .resync_count(m_rs),
    .all_locked(m_all)
  );

  etroc_multi_frame_sync_monitor #(
    .NCH(2), .LOCK_CYCLES(4), .HOLDOFF_CYCLES(8), .MAX_RESYNC(3), .CNT_W(4)
  ) dut_s (
    .clk40(clk40), .reset(reset), .clr_error(s_clr),
    .enable_auto_sync(s_en), .aligned(s_al), .trig_synched(s_ts),
    .link_consistent(s_lc), .data_valid(s_dv), .transient_error(s_te),
    .force_resync(s_fr), .data_error(s_de), .ch_failed(s_fail),
    .ch_state(s_state), .err_count(s_err), .resync_count(s_rs),
    .all_locked(s_all)
  );

  typedef struct {
    logic        sel;   // 0 = main DUT, 1 = small DUT
    logic        clr;
    logic [3:0]  en, al, ts, lc, dv, te;
    int          rep;
    int          ch;
    logic [2:0]  e_state;
    logic [15:0] e_err;
    logic [7:0]  e_rs;
    logic        e_de, e_fr, e_fail, e_all;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int sel, clr, en, al, ts, lc, dv, te, rep, ch,
                              st, err, rs, de, fr, fail, all);
    vec_t v;
    v.sel = 1'(sel); v.clr = 1'(clr);
    v.en = 4'(en); v.al = 4'(al); v.ts = 4'(ts); v.lc = 4'(lc); v.dv = 4'(dv); v.te = 4'(te);
    v.rep = rep; v.ch = ch;
    v.e_state = 3'(st); v.e_err = 16'(err); v.e_rs = 8'(rs);
    v.e_de = 1'(de); v.e_fr = 1'(fr); v.e_fail = 1'(fail); v.e_all = 1'(all);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic drive_idle();
    m_clr = 0; m_en = 0; m_al = 0; m_ts = 0; m_lc = 0; m_dv = 0; m_te = 0;
    s_clr = 0; s_en = 0; s_al = 0; s_ts = 0; s_lc = 0; s_dv = 0; s_te = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    logic [2:0] a_st;
    logic [15:0] a_err;
    logic [7:0] a_rs;
    logic a_de, a_fr, a_fail, a_all;
    drive_idle();
    if (v.sel == 1'b0) begin
      m_clr = v.clr; m_en = v.en; m_al = v.al; m_ts = v.ts;
      m_lc = v.lc; m_dv = v.dv; m_te = v.te;
    end else begin
      s_clr = v.clr; s_en = v.en[1:0]; s_al = v.al[1:0]; s_ts = v.ts[1:0];
      s_lc = v.lc[1:0]; s_dv = v.dv[1:0]; s_te = v.te[1:0];
    end
    exp_q.push_back(v);
    repeat (v.rep) tick();
    e = exp_q.pop_front();
    if (e.sel == 1'b0) begin
      a_st = m_state[3*e.ch +: 3]; a_err = m_err[16*e.ch +: 16]; a_rs = m_rs[8*e.ch +: 8];
      a_de = m_de[e.ch]; a_fr = m_fr[e.ch]; a_fail = m_fail[e.ch]; a_all = m_all;
    end else begin
      a_st = s_state[3*e.ch +: 3]; a_err = {12'd0, s_err[4*e.ch +: 4]}; a_rs = s_rs[8*e.ch +: 8];
      a_de = s_de[e.ch]; a_fr = s_fr[e.ch]; a_fail = s_fail[e.ch]; a_all = s_all;
    end
    $display("vec %0d dut%0d ch%0d: state=%0d err=%0d rs=%0d de=%0b fr=%0b fail=%0b all=%0b",
             idx, e.sel, e.ch, a_st, a_err, a_rs, a_de, a_fr, a_fail, a_all);
    chk($sformatf("v%0d state", idx), 64'(a_st), 64'(e.e_state));
    chk($sformatf("v%0d err_count", idx), 64'(a_err), 64'(e.e_err));
    chk($sformatf("v%0d resync_count", idx), 64'(a_rs), 64'(e.e_rs));
    chk($sformatf("v%0d data_error", idx), 64'(a_de), 64'(e.e_de));
    chk($sformatf("v%0d force_resync", idx), 64'(a_fr), 64'(e.e_fr));
    chk($sformatf("v%0d ch_failed", idx), 64'(a_fail), 64'(e.e_fail));
    chk($sformatf("v%0d all_locked", idx), 64'(a_all), 64'(e.e_all));
  endtask

  initial begin
    //                sel clr en   al   ts   lc   dv   te  rep ch  st err rs de fr fl all
    // lock after LOCK_CYCLES+1 clocks
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,  16, 0,  0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,   1, 0,  1, 0,  0, 0, 0, 0, 0));
    // qualified errors count, unqualified ones do not
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   1,   1,   5, 0,  1, 5,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   1,   3, 0,  1, 5,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   1,   0,   2, 0,  1, 5,  0, 1, 0, 0, 0));
    // auto-sync disabled: inconsistency tolerated
    tbl.push_back(mk(0, 0, 0,   1,   1,   0,   0,   0,   4, 0,  1, 5,  0, 1, 0, 0, 0));
    // auto-resync pulse, then 64 holdoff cycles ignoring errors
    tbl.push_back(mk(0, 0, 1,   1,   1,   0,   0,   0,   1, 0,  2, 5,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,   1, 0,  3, 5,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   0,   1,   1,  62, 0,  3, 5,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   0,   1,   1,   1, 0,  3, 5,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   0,   1,   1,   1, 0,  0, 5,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,  17, 0,  1, 5,  1, 1, 0, 0, 0));
    // clear coincides with error: clear wins, pulse follows, resync_count -> 1
    tbl.push_back(mk(0, 1, 1,   1,   1,   1,   1,   1,   1, 0,  2, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,   1, 0,  3, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,  64, 0,  0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,  17, 0,  1, 0,  1, 0, 0, 0, 0));
    // loss of lock together with inconsistency: unlocked, no pulse
    tbl.push_back(mk(0, 0, 1,   0,   1,   0,   0,   0,   1, 0,  0, 0,  1, 0, 0, 0, 0));
    // one-cycle qualification drop restarts the lock count
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,  10, 0,  0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   0,   1,   1,   0,   0,   1, 0,  0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,  15, 0,  0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   1,   1,   1,   0,   0,   2, 0,  1, 0,  1, 0, 0, 0, 0));
    // all channels lock; ch2 errors stay local
    tbl.push_back(mk(0, 0, 15, 15,  15,  15,   0,   0,  16, 1,  0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 15, 15,  15,  15,   0,   0,   1, 1,  1, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 15, 15,  15,  15,   4,   4,   3, 2,  1, 3,  0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 15, 15,  15,  15,   0,   0,   1, 0,  1, 0,  1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 15, 15,  15,  15,   0,   0,   1, 1,  1, 0,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 15, 15,  15,  15,   0,   0,   1, 3,  1, 0,  0, 0, 0, 0, 1));
    // ch0 resync, into holdoff (async reset follows)
    tbl.push_back(mk(0, 0, 15, 15,  15,  14,   0,   0,   1, 0,  2, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 15, 15,  15,  15,   0,   0,   5, 0,  3, 0,  2, 0, 0, 0, 0));
    // small DUT: saturation at 15, retry limit of 3, clear out of FAILED
    tbl.push_back(mk(1, 0, 1,   1,   1,   1,   0,   0,   5, 0,  1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   1,   1,   1,  20, 0,  1, 15, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   1, 0,  2, 15, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   1, 0,  3, 15, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   8, 0,  0, 15, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   5, 0,  1, 15, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   1, 0,  2, 15, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   1, 0,  3, 15, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   8, 0,  0, 15, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   5, 0,  1, 15, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   1, 0,  2, 15, 2, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,   1, 0,  4, 15, 3, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1,   1,   1,   0,   0,   0,  20, 0,  4, 15, 3, 1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1,   1,   1,   0,   0,   0,   1, 0,  0, 0,  0, 0, 0, 0, 0));

    // reset state
    drive_idle();
    reset = 1'b1;
    repeat (2) tick();
    chk("rst m_state", 64'(m_state), 64'd0);
    chk("rst m_err", m_err, 64'd0);
    chk("rst m_flags", 64'({m_rs, m_fr, m_de, m_fail, m_all}), 64'd0);
    chk("rst s_all", 64'({s_state, s_err, s_rs, s_fr, s_de, s_fail, s_all}), 64'd0);
    @(negedge clk40);
    reset = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 29) begin
        // async reset in the middle of ch0 holdoff: outputs clear before the next edge
        #4;
        reset = 1'b1;
        #1;
        $display("async reset mid-holdoff: m_state=0x%0h m_rs=0x%0h", m_state, m_rs);
        chk("areset m_state", 64'(m_state), 64'd0);
        chk("areset m_rs", 64'(m_rs), 64'd0);
        chk("areset m_fr_all", 64'({m_fr, m_de, m_fail, m_all}), 64'd0);
        @(negedge clk40);
        reset = 1'b0;
        tick();
      end
      run_vec(tbl[i], i);
    end

    // async reset during a resync pulse on the small DUT
    drive_idle();
    s_en = 2'b01; s_al = 2'b01; s_ts = 2'b01; s_lc = 2'b01;
    repeat (5) tick();
    s_lc = 2'b00;
    tick();
    $display("pulse before reset: s_fr=%0b s_state=0x%0h", s_fr, s_state);
    chk("pulse s_fr", 64'(s_fr), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    $display("pulse after reset: s_fr=%0b s_state=0x%0h", s_fr, s_state);
    chk("areset s_fr", 64'(s_fr), 64'd0);
    chk("areset s_state", 64'(s_state), 64'd0);
    @(negedge clk40);
    reset = 1'b0;
    drive_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
